mat_row_bank: RTL and testbench

Synthesizable row-memory responder for the matrix engines (`lu`, `triang_matrix_inv`). It holds one SIZE×SIZE complex double-precision matrix as SIZE rows. It answers the engines' row-read requests with a fixed one-cycle latency and absorbs their row write-backs. A host port loads operands and unloads results, replacing the behavioural row array the engines currently talk to.

---
 rtl/mat_row_pkg.sv | 29 ++
 rtl/mat_row_rd_port.sv | 77 +++++++
 rtl/mat_row_bank.sv | 155 +++++++++++++++
 tb/tb_mat_row_bank.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_row_pkg.sv
// -----------------------------------------------------------------------------
// mat_row_pkg
// Shared types for the matrix row bank: one complex double element, a full
// matrix row, a row address, and an address range helper. The default sizes
// match the matrix engines (16x16 complex doubles).
// -----------------------------------------------------------------------------
package mat_row_pkg;

   localparam int ROW_SIZE  = 16;
   localparam int ROW_WIDTH = 64;
   localparam int ROW_AW    = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;

   // One complex element; the real part sits in the low half. The field is
   // called 're' because 'real' is a reserved word.
   typedef struct packed {
      logic [ROW_WIDTH-1:0] im;
      logic [ROW_WIDTH-1:0] re;
   } cplx_t;

   typedef cplx_t [ROW_SIZE-1:0]  mat_row_t;
   typedef logic  [ROW_AW-1:0]    row_addr_t;

   // True when a row address refers to a real row. Only meaningful for a
   // non-power-of-two SIZE; otherwise it folds to a constant 1.
   function automatic logic addr_in_range(input logic [31:0] addr, input int size);
      return addr < 32'(size);
   endfunction

endpackage

// File: rtl/mat_row_rd_port.sv
// -----------------------------------------------------------------------------
// mat_row_rd_port
// One read port of the row bank: registers a row read with one-cycle latency.
// A write accepted in the same cycle as the read to the same row is forwarded
// so the read returns the new data. Out-of-range rows read back as zero.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         drops the request presented this cycle
//   req_addr_i      requested row
//   req_valid_i     read request strobe
//   mem_row_i       current storage contents of row req_addr_i
//   wr_en_i         a write to an in-range row is accepted this cycle
//   wr_addr_i       row being written
//   wr_row_i        data being written
//   row_o           read data, valid the cycle after the request
//   row_valid_o     single-cycle pulse per accepted request
// -----------------------------------------------------------------------------
module mat_row_rd_port
   import mat_row_pkg::*;
#(
   parameter  int SIZE  = ROW_SIZE,
   parameter  int WIDTH = ROW_WIDTH,
   localparam int AW    = (SIZE > 1) ? $clog2(SIZE) : 1,
   localparam int RW    = SIZE * 2 * WIDTH
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          flush_i,
   input  logic [AW-1:0] req_addr_i,
   input  logic          req_valid_i,
   input  logic [RW-1:0] mem_row_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [RW-1:0] wr_row_i,
   output logic [RW-1:0] row_o,
   output logic          row_valid_o
);

   logic          take;
   logic [RW-1:0] row_d, row_q;
   logic          row_valid_d, row_valid_q;

   // NOTE: every variable written here is given a value before any branch;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      take        = req_valid_i & ~flush_i;
      row_valid_d = take;
      row_d       = row_q;
      if (take) begin
         if (!addr_in_range(32'(req_addr_i), SIZE)) begin
            row_d = '0;
         end else if (wr_en_i && (wr_addr_i == req_addr_i)) begin
            // Write-first: storage only updates at the edge, so bypass it.
            row_d = wr_row_i;
         end else begin
            row_d = mem_row_i;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its pre-edge value regardless of process evaluation order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         row_q       <= '0;
         row_valid_q <= 1'b0;
      end else begin
         row_q       <= row_d;
         row_valid_q <= row_valid_d;
      end
   end

   assign row_o       = row_q;
   assign row_valid_o = row_valid_q;

endmodule

// File: rtl/mat_row_bank.sv
// -----------------------------------------------------------------------------
// mat_row_bank
// Row memory for the matrix engines: SIZE rows of SIZE complex elements.
// The engine port reads rows with one-cycle latency and writes rows back; the
// host port loads operands and unloads results. Engine writes win arbitration
// over host writes. A bitmap records which rows the engine has written.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   flush_i                    drops in-flight reads, clears the bitmap
//   rd_addr_i/rd_addr_valid_i  engine read request
//   rd_row_o/rd_addr_o/rd_row_valid_o  engine read response (t+1)
//   wr_row_i/wr_addr_i/wr_valid_i/wr_ready_o  engine write-back
//   host_wr_row_i/host_wr_addr_i/host_wr_valid_i/host_wr_ready_o  host load
//   host_rd_addr_i/host_rd_valid_i  host unload request
//   host_rd_row_o/host_rd_row_valid_o  host unload response (t+1)
//   rows_written_o/all_written_o  engine-written row bitmap and its AND
//   clear_i                    clears the bitmap only
// -----------------------------------------------------------------------------
module mat_row_bank
   import mat_row_pkg::*;
#(
   parameter  int SIZE  = ROW_SIZE,
   parameter  int WIDTH = ROW_WIDTH,
   localparam int AW    = (SIZE > 1) ? $clog2(SIZE) : 1,
   localparam int RW    = SIZE * 2 * WIDTH
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic [AW-1:0]   rd_addr_i,
   input  logic            rd_addr_valid_i,
   output logic [RW-1:0]   rd_row_o,
   output logic [AW-1:0]   rd_addr_o,
   output logic            rd_row_valid_o,
   input  logic [RW-1:0]   wr_row_i,
   input  logic [AW-1:0]   wr_addr_i,
   input  logic            wr_valid_i,
   output logic            wr_ready_o,
   input  logic [RW-1:0]   host_wr_row_i,
   input  logic [AW-1:0]   host_wr_addr_i,
   input  logic            host_wr_valid_i,
   output logic            host_wr_ready_o,
   input  logic [AW-1:0]   host_rd_addr_i,
   input  logic            host_rd_valid_i,
   output logic [RW-1:0]   host_rd_row_o,
   output logic            host_rd_row_valid_o,
   output logic [SIZE-1:0] rows_written_o,
   output logic            all_written_o,
   input  logic            clear_i
);

   logic            eng_wr_acc;
   logic            host_wr_acc;
   logic            wr_en_ok;
   logic [AW-1:0]   wr_addr;
   logic [RW-1:0]   wr_row;
   logic [RW-1:0]   mem_q [SIZE];
   logic [AW-1:0]   rd_addr_d, rd_addr_q;
   logic [SIZE-1:0] rows_written_d, rows_written_q;
   logic            all_written_d, all_written_q;

   // Readiness comes straight from reset and the engine strobe so a stalled
   // host sees the back-pressure in the same cycle.
   assign wr_ready_o      = rst_ni;
   assign host_wr_ready_o = rst_ni & ~wr_valid_i;

   // Single write path shared by both sources; the engine has priority.
   always_comb begin
      eng_wr_acc  = rst_ni & wr_valid_i;
      host_wr_acc = rst_ni & host_wr_valid_i & ~wr_valid_i;
      wr_addr     = eng_wr_acc ? wr_addr_i : host_wr_addr_i;
      wr_row      = eng_wr_acc ? wr_row_i  : host_wr_row_i;
      wr_en_ok    = (eng_wr_acc | host_wr_acc) & addr_in_range(32'(wr_addr), SIZE);
   end

   // NOTE: the row storage has no reset; clearing wide arrays costs routing
   // for nothing since contents are meaningless until written.
   always_ff @(posedge clk_i) begin
      if (wr_en_ok) begin
         mem_q[wr_addr] <= wr_row;
      end
   end

   // Engine read data and echoed address; the host port has no echo.
   mat_row_rd_port #(
      .SIZE  (SIZE),
      .WIDTH (WIDTH)
   ) u_eng_rd (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .req_addr_i  (rd_addr_i),
      .req_valid_i (rd_addr_valid_i),
      .mem_row_i   (mem_q[rd_addr_i]),
      .wr_en_i     (wr_en_ok),
      .wr_addr_i   (wr_addr),
      .wr_row_i    (wr_row),
      .row_o       (rd_row_o),
      .row_valid_o (rd_row_valid_o)
   );

   mat_row_rd_port #(
      .SIZE  (SIZE),
      .WIDTH (WIDTH)
   ) u_host_rd (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .req_addr_i  (host_rd_addr_i),
      .req_valid_i (host_rd_valid_i),
      .mem_row_i   (mem_q[host_rd_addr_i]),
      .wr_en_i     (wr_en_ok),
      .wr_addr_i   (wr_addr),
      .wr_row_i    (wr_row),
      .row_o       (host_rd_row_o),
      .row_valid_o (host_rd_row_valid_o)
   );

   always_comb begin
      rd_addr_d = rd_addr_q;
      if (rd_addr_valid_i && !flush_i) begin
         rd_addr_d = rd_addr_i;
      end
   end

   always_comb begin
      rows_written_d = rows_written_q;
      if (eng_wr_acc && addr_in_range(32'(wr_addr_i), SIZE)) begin
         rows_written_d[wr_addr_i] = 1'b1;
      end
      // Placed last so a clear in the same cycle as a write leaves the bit 0.
      if (clear_i || flush_i) begin
         rows_written_d = '0;
      end
      all_written_d = &rows_written_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_addr_q      <= '0;
         rows_written_q <= '0;
         all_written_q  <= 1'b0;
      end else begin
         rd_addr_q      <= rd_addr_d;
         rows_written_q <= rows_written_d;
         all_written_q  <= all_written_d;
      end
   end

   assign rd_addr_o      = rd_addr_q;
   assign rows_written_o = rows_written_q;
   assign all_written_o  = all_written_q;

endmodule

// File: tb/tb_mat_row_bank.sv
// -----------------------------------------------------------------------------
// tb_mat_row_bank
// Directed stimulus with a scoreboard: each read request pushes its expected
// response, tagged with the cycle it is due, and per-port monitors compare on
// the falling edge. Control-path values are checked inline.
// -----------------------------------------------------------------------------
module tb_mat_row_bank;
   import mat_row_pkg::*;

   localparam int SZ = 16;
   localparam int W  = 64;
   localparam int RW = SZ * 2 * W;
   localparam int AW = 4;

   typedef struct {
      int            due;
      logic [AW-1:0] addr;
      logic [RW-1:0] row;
   } exp_t;

   logic            clk_i;
   logic            rst_ni;
   logic            flush_i;
   logic [AW-1:0]   rd_addr_i;
   logic            rd_addr_valid_i;
   logic [RW-1:0]   rd_row_o;
   logic [AW-1:0]   rd_addr_o;
   logic            rd_row_valid_o;
   logic [RW-1:0]   wr_row_i;
   logic [AW-1:0]   wr_addr_i;
   logic            wr_valid_i;
   logic            wr_ready_o;
   logic [RW-1:0]   host_wr_row_i;
   logic [AW-1:0]   host_wr_addr_i;
   logic            host_wr_valid_i;
   logic            host_wr_ready_o;
   logic [AW-1:0]   host_rd_addr_i;
   logic            host_rd_valid_i;
   logic [RW-1:0]   host_rd_row_o;
   logic            host_rd_row_valid_o;
   logic [SZ-1:0]   rows_written_o;
   logic            all_written_o;
   logic            clear_i;

   int   nchecks = 0;
   int   nerr    = 0;
   int   cyc     = 0;
   exp_t eng_q[$];
   exp_t host_q[$];

   mat_row_bank #(.SIZE(SZ), .WIDTH(W)) dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .flush_i             (flush_i),
      .rd_addr_i           (rd_addr_i),
      .rd_addr_valid_i     (rd_addr_valid_i),
      .rd_row_o            (rd_row_o),
      .rd_addr_o           (rd_addr_o),
      .rd_row_valid_o      (rd_row_valid_o),
      .wr_row_i            (wr_row_i),
      .wr_addr_i           (wr_addr_i),
      .wr_valid_i          (wr_valid_i),
      .wr_ready_o          (wr_ready_o),
      .host_wr_row_i       (host_wr_row_i),
      .host_wr_addr_i      (host_wr_addr_i),
      .host_wr_valid_i     (host_wr_valid_i),
      .host_wr_ready_o     (host_wr_ready_o),
      .host_rd_addr_i      (host_rd_addr_i),
      .host_rd_valid_i     (host_rd_valid_i),
      .host_rd_row_o       (host_rd_row_o),
      .host_rd_row_valid_o (host_rd_row_valid_o),
      .rows_written_o      (rows_written_o),
      .all_written_o       (all_written_o),
      .clear_i             (clear_i)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   always @(posedge clk_i) cyc <= cyc + 1;

   // Row r, element j: real = base + r*16 + j, imag = -(base + r*16 + j).
   function automatic logic [RW-1:0] pat(input int r, input int base);
      mat_row_t row;
      for (int j = 0; j < SZ; j++) begin
         row[j].re = $realtobits(real'(base + r * 16 + j));
         row[j].im = $realtobits(-real'(base + r * 16 + j));
      end
      return row;
   endfunction

   task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_row(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      int k;
      k = 0;
      nchecks++;
      if (act !== exp) begin
         nerr++;
         for (int j = SZ - 1; j >= 0; j--) begin
            if (act[j*2*W +: 2*W] !== exp[j*2*W +: 2*W]) k = j;
         end
         $display("FAIL %s: element %0d got %h expected %h (t=%0t)",
                  nm, k, act[k*2*W +: 2*W], exp[k*2*W +: 2*W], $time);
      end
   endtask

   task automatic push_eng(input logic [AW-1:0] a, input logic [RW-1:0] d);
      eng_q.push_back('{due: cyc + 1, addr: a, row: d});
   endtask

   task automatic push_host(input logic [RW-1:0] d);
      host_q.push_back('{due: cyc + 1, addr: '0, row: d});
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Engine-port monitor.
   always @(negedge clk_i) begin : eng_mon
      exp_t e;
      if (eng_q.size() != 0 && eng_q[0].due == cyc) begin
         e = eng_q.pop_front();
         check_val("eng_valid", 32'(rd_row_valid_o), 32'd1);
         check_row("eng_data", rd_row_o, e.row);
         check_val("eng_addr", 32'(rd_addr_o), 32'(e.addr));
      end else if (rd_row_valid_o) begin
         check_val("eng_unexpected_valid", 32'(rd_row_valid_o), 32'd0);
      end
   end

   // Host-port monitor.
   always @(negedge clk_i) begin : host_mon
      exp_t e;
      if (host_q.size() != 0 && host_q[0].due == cyc) begin
         e = host_q.pop_front();
         check_val("host_valid", 32'(host_rd_row_valid_o), 32'd1);
         check_row("host_data", host_rd_row_o, e.row);
      end else if (host_rd_row_valid_o) begin
         check_val("host_unexpected_valid", 32'(host_rd_row_valid_o), 32'd0);
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check_all_zero(input string tag);
      check_row({tag, "_rd_row"}, rd_row_o, '0);
      check_val({tag, "_rd_addr"}, 32'(rd_addr_o), 32'd0);
      check_val({tag, "_rd_valid"}, 32'(rd_row_valid_o), 32'd0);
      check_row({tag, "_host_row"}, host_rd_row_o, '0);
      check_val({tag, "_host_valid"}, 32'(host_rd_row_valid_o), 32'd0);
      check_val({tag, "_bitmap"}, 32'(rows_written_o), 32'd0);
      check_val({tag, "_all_written"}, 32'(all_written_o), 32'd0);
      check_val({tag, "_wr_ready"}, 32'(wr_ready_o), 32'd0);
      check_val({tag, "_host_wr_ready"}, 32'(host_wr_ready_o), 32'd0);
   endtask

   initial begin
      rst_ni          = 1'b0;
      flush_i         = 1'b0;
      clear_i         = 1'b0;
      rd_addr_i       = '0;
      rd_addr_valid_i = 1'b0;
      wr_row_i        = '0;
      wr_addr_i       = '0;
      wr_valid_i      = 1'b0;
      host_wr_row_i   = '0;
      host_wr_addr_i  = '0;
      host_wr_valid_i = 1'b0;
      host_rd_addr_i  = '0;
      host_rd_valid_i = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk_i);
      #1;
      check_all_zero("reset");
      rst_ni = 1'b1;
      tick();

      // Host loads all rows, engine reads them back-to-back.
      for (int r = 0; r < SZ; r++) begin
         host_wr_valid_i = 1'b1;
         host_wr_addr_i  = 4'(r);
         host_wr_row_i   = pat(r, 0);
         if (r == 0) begin
            #1;
            check_val("host_ready_idle", 32'(host_wr_ready_o), 32'd1);
            check_val("eng_ready_idle", 32'(wr_ready_o), 32'd1);
         end
         tick();
      end
      host_wr_valid_i = 1'b0;
      for (int r = 0; r < SZ; r++) begin
         rd_addr_valid_i = 1'b1;
         rd_addr_i       = 4'(r);
         push_eng(4'(r), pat(r, 0));
         tick();
      end
      rd_addr_valid_i = 1'b0;
      check_val("bitmap_after_host_load", 32'(rows_written_o), 32'd0);
      host_rd_valid_i = 1'b1;
      host_rd_addr_i  = 4'd7;
      push_host(pat(7, 0));
      tick();
      host_rd_valid_i = 1'b0;

      // Engine write and both-port read of row 5 in the same cycle.
      wr_valid_i      = 1'b1;
      wr_addr_i       = 4'd5;
      wr_row_i        = pat(5, 1000);
      rd_addr_valid_i = 1'b1;
      rd_addr_i       = 4'd5;
      push_eng(4'd5, pat(5, 1000));
      host_rd_valid_i = 1'b1;
      host_rd_addr_i  = 4'd5;
      push_host(pat(5, 1000));
      tick();
      wr_valid_i      = 1'b0;
      rd_addr_valid_i = 1'b0;
      host_rd_valid_i = 1'b0;
      check_val("bitmap_row5", 32'(rows_written_o), 32'h0020);
      check_val("all_written_partial", 32'(all_written_o), 32'd0);

      // Host write to row 3 held behind three engine writes to row 9.
      host_wr_valid_i = 1'b1;
      host_wr_addr_i  = 4'd3;
      host_wr_row_i   = pat(3, 2000);
      for (int k = 0; k < 3; k++) begin
         wr_valid_i      = 1'b1;
         wr_addr_i       = 4'd9;
         wr_row_i        = pat(9, 3000);
         rd_addr_valid_i = 1'b1;
         rd_addr_i       = 4'd3;
         push_eng(4'd3, pat(3, 0));
         #1;
         check_val("host_ready_stalled", 32'(host_wr_ready_o), 32'd0);
         tick();
      end
      wr_valid_i      = 1'b0;
      rd_addr_i       = 4'd9;
      push_eng(4'd9, pat(9, 3000));
      host_rd_valid_i = 1'b1;
      host_rd_addr_i  = 4'd3;
      push_host(pat(3, 2000));
      #1;
      check_val("host_ready_release", 32'(host_wr_ready_o), 32'd1);
      tick();
      host_wr_valid_i = 1'b0;
      host_rd_valid_i = 1'b0;
      rd_addr_i       = 4'd3;
      push_eng(4'd3, pat(3, 2000));
      tick();
      rd_addr_valid_i = 1'b0;
      check_val("bitmap_rows_5_9", 32'(rows_written_o), 32'h0220);

      // Engine writes every row; all_written rises after the last one.
      for (int r = 0; r < SZ; r++) begin
         wr_valid_i = 1'b1;
         wr_addr_i  = 4'(r);
         wr_row_i   = pat(r, 4000);
         tick();
         check_val("all_written_step", 32'(all_written_o), (r == SZ - 1) ? 32'd1 : 32'd0);
      end
      check_val("bitmap_full", 32'(rows_written_o), 32'hffff);

      // Clear coinciding with a write to row 0: clear wins, write still lands.
      wr_addr_i = 4'd0;
      wr_row_i  = pat(0, 4500);
      clear_i   = 1'b1;
      tick();
      clear_i    = 1'b0;
      wr_valid_i = 1'b0;
      check_val("bitmap_after_clear", 32'(rows_written_o), 32'd0);
      check_val("all_written_after_clear", 32'(all_written_o), 32'd0);
      rd_addr_valid_i = 1'b1;
      rd_addr_i       = 4'd0;
      push_eng(4'd0, pat(0, 4500));
      tick();

      // Read row 1 and write row 2, then flush with a read and write of row 4.
      rd_addr_i  = 4'd1;
      push_eng(4'd1, pat(1, 4000));
      wr_valid_i = 1'b1;
      wr_addr_i  = 4'd2;
      wr_row_i   = pat(2, 4000);
      tick();
      check_val("bitmap_before_flush", 32'(rows_written_o), 32'h0004);
      wr_addr_i       = 4'd4;
      wr_row_i        = pat(4, 5000);
      rd_addr_i       = 4'd4;
      host_rd_valid_i = 1'b1;
      host_rd_addr_i  = 4'd4;
      flush_i         = 1'b1;
      tick();
      flush_i         = 1'b0;
      wr_valid_i      = 1'b0;
      rd_addr_valid_i = 1'b0;
      host_rd_valid_i = 1'b0;
      check_val("flush_eng_valid", 32'(rd_row_valid_o), 32'd0);
      check_val("flush_host_valid", 32'(host_rd_row_valid_o), 32'd0);
      check_val("bitmap_after_flush", 32'(rows_written_o), 32'd0);
      rd_addr_valid_i = 1'b1;
      rd_addr_i       = 4'd4;
      push_eng(4'd4, pat(4, 5000));
      tick();

      // Reset pulse in the middle of a read burst.
      rd_addr_i  = 4'd1;
      push_eng(4'd1, pat(1, 4000));
      wr_valid_i = 1'b1;
      wr_addr_i  = 4'd7;
      wr_row_i   = pat(7, 6000);
      tick();
      wr_valid_i = 1'b0;
      rd_addr_i  = 4'd2;
      @(negedge clk_i);
      #1;
      check_val("bitmap_before_reset", 32'(rows_written_o), 32'h0080);
      rst_ni = 1'b0;
      #1;
      check_all_zero("async_reset");
      repeat (2) @(posedge clk_i);
      #1;
      check_val("in_reset_valid", 32'(rd_row_valid_o), 32'd0);
      check_val("in_reset_wr_ready", 32'(wr_ready_o), 32'd0);
      rd_addr_valid_i = 1'b0;
      rst_ni          = 1'b1;
      tick();
      check_val("post_reset_valid", 32'(rd_row_valid_o), 32'd0);
      check_val("post_reset_bitmap", 32'(rows_written_o), 32'd0);
      rd_addr_valid_i = 1'b1;
      rd_addr_i       = 4'd4;
      push_eng(4'd4, pat(4, 5000));
      tick();
      rd_addr_valid_i = 1'b0;

      repeat (3) tick();
      check_val("eng_queue_drained", 32'(eng_q.size()), 32'd0);
      check_val("host_queue_drained", 32'(host_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
